// File: rtl/sdram_resp_model.sv
// sdram_resp_model: cycle-accurate SDRAM device responder for controller test benches.
// Decodes SDR commands, keeps a small word-addressed memory per bank and returns read
// bursts after the programmed CAS latency.
// Optional build macro SDRAM_RESP_PROTO_CHK_EN adds a sticky protocol checker; without it
// proto_err/err_code are constant zero.
module sdram_resp_model #(
  parameter int unsigned SDR_DW   = 32,
  parameter int unsigned SDR_BW   = 4,
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned COL_BITS = 6
) (
  input  logic              sdram_clk,
  input  logic              sdram_reset,
  input  logic              sdr_cke,
  input  logic              sdr_cs_n,
  input  logic              sdr_ras_n,
  input  logic              sdr_cas_n,
  input  logic              sdr_we_n,
  input  logic [1:0]        sdr_ba,
  input  logic [12:0]       sdr_addr,
  input  logic [SDR_BW-1:0] sdr_dqm,
  input  logic [SDR_DW-1:0] sdr_dq_in,
  output logic [SDR_DW-1:0] sdr_dq_out,
  output logic              sdr_dq_oe,
  output logic              mode_set,
  output logic [15:0]       ref_cnt,
  output logic              proto_err,
  output logic [2:0]        err_code
);

  localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [2:0] {
    CmdMrs = 3'b000,
    CmdRef = 3'b001,
    CmdPre = 3'b010,
    CmdAct = 3'b011,
    CmdWr  = 3'b100,
    CmdRd  = 3'b101,
    CmdBst = 3'b110,
    CmdNop = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } burst_st_e;

  // Last beat index (BL-1) for a log2 burst length; doubles as the column wrap mask.
  function automatic logic [2:0] last_beat(input logic [1:0] lg);
    logic [2:0] r;
    case (lg)
      2'd1:    r = 3'd1;
      2'd2:    r = 3'd3;
      2'd3:    r = 3'd7;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Column of beat k: low log2(BL) bits count from the start column and wrap in the block.
  function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] start,
                                                  input logic [1:0] lg,
                                                  input logic [2:0] k);
    logic [COL_BITS-1:0] mask;
    mask = COL_BITS'(last_beat(lg));
    return (start & ~mask) | ((start + COL_BITS'(k)) & mask);
  endfunction

  cmd_e cmd;
  assign cmd = (sdr_cke && !sdr_cs_n) ? cmd_e'({sdr_ras_n, sdr_cas_n, sdr_we_n}) : CmdNop;

  logic cmd_rw;
  assign cmd_rw = (cmd == CmdWr) || (cmd == CmdRd);

  // ---------------------------------------------------------------------------------------
  // Mode register and refresh counter
  // ---------------------------------------------------------------------------------------
  logic [1:0]  bl_log_q, bl_log_d;  // log2 of burst length
  logic        cl2_q, cl2_d;        // 1: CL2, 0: CL3
  logic        mode_set_q;
  logic [15:0] ref_cnt_q;

  // MRS decode of burst length and CAS latency.
  always_comb begin
    bl_log_d = bl_log_q;
    cl2_d    = cl2_q;
    if (cmd == CmdMrs) begin
      case (sdr_addr[2:0])
        3'b001:  bl_log_d = 2'd1;
        3'b010:  bl_log_d = 2'd2;
        3'b011:  bl_log_d = 2'd3;
        default: bl_log_d = 2'd0;
      endcase
      cl2_d = (sdr_addr[6:4] == 3'b010);
    end
  end

  // Mode and refresh state.
  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      bl_log_q   <= 2'd0;
      cl2_q      <= 1'b0;
      mode_set_q <= 1'b0;
      ref_cnt_q  <= 16'd0;
    end else begin
      bl_log_q <= bl_log_d;
      cl2_q    <= cl2_d;
      if (cmd == CmdMrs) begin
        mode_set_q <= 1'b1;
      end
      if ((cmd == CmdRef) && (ref_cnt_q != 16'hFFFF)) begin
        ref_cnt_q <= ref_cnt_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Bank state
  // ---------------------------------------------------------------------------------------
  logic [3:0]          bank_open_q;
  logic [ROW_BITS-1:0] bank_row_q [4];

  // ACT opens and latches the row; PRE closes one bank or all with A10.
  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      bank_open_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        bank_row_q[i] <= '0;
      end
    end else begin
      if (cmd == CmdAct) begin
        bank_open_q[sdr_ba] <= 1'b1;
        bank_row_q[sdr_ba]  <= sdr_addr[ROW_BITS-1:0];
      end else if (cmd == CmdPre) begin
        if (sdr_addr[10]) begin
          bank_open_q <= 4'b0000;
        end else begin
          bank_open_q[sdr_ba] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Burst generator
  // ---------------------------------------------------------------------------------------
  // Beat 0 is serviced on the command edge itself; the FSM carries beats 1..BL-1.
  burst_st_e           bst_q, bst_d;
  logic [2:0]          beat_q, beat_d;
  logic [1:0]          blen_q, blen_d;
  logic                bcl2_q, bcl2_d;
  logic [1:0]          bba_q, bba_d;
  logic [ROW_BITS-1:0] brow_q, brow_d;
  logic [COL_BITS-1:0] bcol_q, bcol_d;

  logic pre_hit;
  logic burst_go;
  assign pre_hit  = (cmd == CmdPre) && (sdr_addr[10] || (sdr_ba == bba_q));
  assign burst_go = (bst_q != StIdle) && !cmd_rw && (cmd != CmdBst) && !pre_hit;

  // Burst FSM next state: new RD/WR restarts it, BST/PRE kill it, otherwise count beats.
  always_comb begin
    bst_d  = bst_q;
    beat_d = beat_q;
    blen_d = blen_q;
    bcl2_d = bcl2_q;
    bba_d  = bba_q;
    brow_d = brow_q;
    bcol_d = bcol_q;
    if (cmd_rw) begin
      if (bl_log_q == 2'd0) begin
        bst_d = StIdle;
      end else begin
        bst_d = (cmd == CmdRd) ? StRead : StWrite;
      end
      beat_d = 3'd1;
      blen_d = bl_log_q;
      bcl2_d = cl2_q;
      bba_d  = sdr_ba;
      brow_d = bank_row_q[sdr_ba];
      bcol_d = sdr_addr[COL_BITS-1:0];
    end else if (bst_q != StIdle) begin
      if (!burst_go || (beat_q == last_beat(blen_q))) begin
        bst_d = StIdle;
      end else begin
        beat_d = beat_q + 3'd1;
      end
    end
  end

  // Burst state register.
  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      bst_q  <= StIdle;
      beat_q <= 3'd0;
      blen_q <= 2'd0;
      bcl2_q <= 1'b0;
      bba_q  <= 2'd0;
      brow_q <= '0;
      bcol_q <= '0;
    end else begin
      bst_q  <= bst_d;
      beat_q <= beat_d;
      blen_q <= blen_d;
      bcl2_q <= bcl2_d;
      bba_q  <= bba_d;
      brow_q <= brow_d;
      bcol_q <= bcol_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Memory access for this edge
  // ---------------------------------------------------------------------------------------
  logic          acc_wr;
  logic          acc_rd;
  logic          acc_cl2;
  logic [AW-1:0] acc_idx;

  // Select the command's own beat 0 or the continuing burst beat.
  always_comb begin
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    acc_cl2 = cl2_q;
    acc_idx = {sdr_ba, bank_row_q[sdr_ba], sdr_addr[COL_BITS-1:0]};
    if (cmd == CmdWr) begin
      acc_wr = 1'b1;
    end else if (cmd == CmdRd) begin
      acc_rd = 1'b1;
    end else if (burst_go) begin
      acc_wr  = (bst_q == StWrite);
      acc_rd  = (bst_q == StRead);
      acc_cl2 = bcl2_q;
      acc_idx = {bba_q, brow_q, beat_col(bcol_q, blen_q, beat_q)};
    end
  end

  logic [SDR_DW-1:0] mem_q [Depth];

  // Byte-masked write port; contents survive reset but the reset edge itself never writes.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_reset && acc_wr) begin
      for (int b = 0; b < int'(SDR_BW); b++) begin
        if (!sdr_dqm[b]) begin
          mem_q[acc_idx][b*8 +: 8] <= sdr_dq_in[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Read delay line: slot 0 drives the bus; a beat enters at slot CL-1 so it is on the bus
  // for sampling exactly CL edges after it was generated. CL is carried per beat.
  // ---------------------------------------------------------------------------------------
  logic [SDR_DW-1:0] pipe_data_q [3];
  logic [SDR_DW-1:0] pipe_data_d [3];
  logic [2:0]        pipe_vld_q, pipe_vld_d;

  // Shift toward the bus, flush on WR, insert the newly read beat.
  always_comb begin
    pipe_data_d[0] = pipe_data_q[1];
    pipe_data_d[1] = pipe_data_q[2];
    pipe_data_d[2] = '0;
    pipe_vld_d     = {1'b0, pipe_vld_q[2:1]};
    if (cmd == CmdWr) begin
      pipe_data_d[0] = '0;
      pipe_data_d[1] = '0;
      pipe_vld_d     = 3'b000;
    end else if (acc_rd) begin
      if (acc_cl2) begin
        pipe_data_d[1] = mem_q[acc_idx];
        pipe_vld_d[1]  = 1'b1;
      end else begin
        pipe_data_d[2] = mem_q[acc_idx];
        pipe_vld_d[2]  = 1'b1;
      end
    end
  end

  // Delay line registers.
  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      pipe_vld_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < 3; i++) begin
        pipe_data_q[i] <= pipe_data_d[i];
      end
    end
  end

  assign sdr_dq_out = pipe_data_q[0];
  assign sdr_dq_oe  = pipe_vld_q[0];
  assign mode_set   = mode_set_q;
  assign ref_cnt    = ref_cnt_q;

  // Address bits outside the decoded fields and bank state only observed by the checker.
  logic unused_in;
  assign unused_in = ^{sdr_addr, bank_open_q};

  // ---------------------------------------------------------------------------------------
  // Protocol checker
  // ---------------------------------------------------------------------------------------
`ifdef SDRAM_RESP_PROTO_CHK_EN
  logic       perr_q;
  logic [2:0] ecode_q;
  logic [2:0] viol_d;

  // Classify this edge's command; the lowest code wins when several apply.
  always_comb begin
    viol_d = 3'd0;
    if ((cmd != CmdNop) && (cmd != CmdMrs) && !mode_set_q) begin
      viol_d = 3'd1;
    end else if ((cmd == CmdAct) && bank_open_q[sdr_ba]) begin
      viol_d = 3'd2;
    end else if (cmd_rw && !bank_open_q[sdr_ba]) begin
      viol_d = 3'd3;
    end else if ((cmd == CmdRef) && (|bank_open_q)) begin
      viol_d = 3'd4;
    end
  end

  // Sticky error: only the first violation after reset is recorded.
  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      perr_q  <= 1'b0;
      ecode_q <= 3'd0;
    end else if (!perr_q && (viol_d != 3'd0)) begin
      perr_q  <= 1'b1;
      ecode_q <= viol_d;
    end
  end

  assign proto_err = perr_q;
  assign err_code  = ecode_q;
`else
  assign proto_err = 1'b0;
  assign err_code  = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_resp_model.sv
// Bench for sdram_resp_model: directed command sequences; each expected read beat is queued
// with the edge it must be sampled on and checked by a separate bus monitor.
module tb_sdram_resp_model;

  localparam logic [2:0] CmdMrs = 3'b000;
  localparam logic [2:0] CmdRef = 3'b001;
  localparam logic [2:0] CmdPre = 3'b010;
  localparam logic [2:0] CmdAct = 3'b011;
  localparam logic [2:0] CmdWr  = 3'b100;
  localparam logic [2:0] CmdRd  = 3'b101;
  localparam logic [2:0] CmdBst = 3'b110;
  localparam logic [2:0] CmdNop = 3'b111;

`ifdef SDRAM_RESP_PROTO_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk         = 1'b0;
  logic        sdram_reset = 1'b1;
  logic        sdr_cke     = 1'b1;
  logic        sdr_cs_n    = 1'b1;
  logic        sdr_ras_n   = 1'b1;
  logic        sdr_cas_n   = 1'b1;
  logic        sdr_we_n    = 1'b1;
  logic [1:0]  sdr_ba      = 2'd0;
  logic [12:0] sdr_addr    = 13'd0;
  logic [3:0]  sdr_dqm     = 4'd0;
  logic [31:0] sdr_dq_in   = 32'd0;
  logic [31:0] sdr_dq_out;
  logic        sdr_dq_oe;
  logic        mode_set;
  logic [15:0] ref_cnt;
  logic        proto_err;
  logic [2:0]  err_code;

  sdram_resp_model dut (
    .sdram_clk  (clk),
    .sdram_reset(sdram_reset),
    .sdr_cke    (sdr_cke),
    .sdr_cs_n   (sdr_cs_n),
    .sdr_ras_n  (sdr_ras_n),
    .sdr_cas_n  (sdr_cas_n),
    .sdr_we_n   (sdr_we_n),
    .sdr_ba     (sdr_ba),
    .sdr_addr   (sdr_addr),
    .sdr_dqm    (sdr_dqm),
    .sdr_dq_in  (sdr_dq_in),
    .sdr_dq_out (sdr_dq_out),
    .sdr_dq_oe  (sdr_dq_oe),
    .mode_set   (mode_set),
    .ref_cnt    (ref_cnt),
    .proto_err  (proto_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    edge_n   = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: at each falling edge the bus holds what the next rising edge samples.
  always @(negedge clk) begin
    beat_t b;
    if (sdr_dq_oe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_beat_unexpected edge %0d: got %h, required no beat", edge_n + 1,
                 sdr_dq_out);
      end else begin
        b = exp_q.pop_front();
        if ((b.edge_no != edge_n + 1) || (b.data !== sdr_dq_out)) begin
          failures++;
          $display("FAIL rd_beat: got %h at edge %0d, required %h at edge %0d", sdr_dq_out,
                   edge_n + 1, b.data, b.edge_no);
        end
      end
    end else begin
      checks++;
      if (sdr_dq_out !== 32'd0) begin
        failures++;
        $display("FAIL idle_bus edge %0d: got %h, required 00000000", edge_n + 1, sdr_dq_out);
      end
      if ((exp_q.size() != 0) && (exp_q[0].edge_no <= edge_n + 1)) begin
        checks++;
        failures++;
        $display("FAIL rd_beat_missing: got no beat at edge %0d, required %h at edge %0d",
                 edge_n + 1, exp_q[0].data, exp_q[0].edge_no);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input int ed, input logic [31:0] d);
    beat_t b;
    b.edge_no = ed;
    b.data    = d;
    exp_q.push_back(b);
  endtask

  // Issue one command; e is the rising edge that samples it.
  task automatic drive(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [3:0] dqm, input logic [31:0] dq, output int e);
    @(negedge clk);
    sdr_cke   = 1'b1;
    sdr_cs_n  = 1'b0;
    {sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
    sdr_ba    = ba;
    sdr_addr  = addr;
    sdr_dqm   = dqm;
    sdr_dq_in = dq;
    e = edge_n + 1;
  endtask

  // Deselected cycles with MRS strobes on the bus: must decode as NOP.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sdr_cke   = 1'b1;
      sdr_cs_n  = 1'b1;
      {sdr_ras_n, sdr_cas_n, sdr_we_n} = 3'b000;
      sdr_addr  = 13'd0;
      sdr_dqm   = 4'd0;
      sdr_dq_in = 32'd0;
    end
  endtask

  // Write data beat with CKE low and RD strobes: must decode as NOP.
  task automatic wbeat(input logic [31:0] dq);
    @(negedge clk);
    sdr_cke   = 1'b0;
    sdr_cs_n  = 1'b0;
    {sdr_ras_n, sdr_cas_n, sdr_we_n} = CmdRd;
    sdr_dqm   = 4'd0;
    sdr_dq_in = dq;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    sdram_reset = 1'b1;
    sdr_cke     = 1'b1;
    sdr_cs_n    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sdram_reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_oe"}, 32'(sdr_dq_oe), 32'd0);
    check({tag, "_dq"}, sdr_dq_out, 32'd0);
    check({tag, "_mode_set"}, 32'(mode_set), 32'd0);
    check({tag, "_ref_cnt"}, 32'(ref_cnt), 32'd0);
    check({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  logic [31:0] exp_bl8 [8];
  logic [31:0] exp_rst [8];

  initial begin
    int e;
    int r;
    repeat (2) @(negedge clk);
    sdram_reset = 1'b0;
    check_reset_state("rst0");

    // Protocol checker sequence before any MRS.
    drive(CmdAct, 2'd0, 13'h001, 4'h0, 32'h0, e);
    idle(1);
    check("err_act_before_mrs", 32'(err_code), ChkEn ? 32'd1 : 32'd0);
    check("perr_act_before_mrs", 32'(proto_err), 32'(ChkEn));
    drive(CmdAct, 2'd0, 13'h001, 4'h0, 32'h0, e);
    drive(CmdAct, 2'd0, 13'h002, 4'h0, 32'h0, e);
    idle(1);
    check("err_code_sticky", 32'(err_code), ChkEn ? 32'd1 : 32'd0);
    for (int i = 0; i < 3; i++) drive(CmdRef, 2'd0, 13'h000, 4'h0, 32'h0, e);
    idle(1);
    check("ref_cnt_3", 32'(ref_cnt), 32'd3);
    apply_reset();
    check_reset_state("rst1");

    // CL2 BL4: write A0..A3 at col 5 (cols 5,6,7,4), read back with DQM set (ignored).
    drive(CmdMrs, 2'd0, 13'h022, 4'h0, 32'h0, e);
    drive(CmdAct, 2'd1, 13'h003, 4'h0, 32'h0, e);
    idle(1);
    check("mode_set", 32'(mode_set), 32'd1);
    drive(CmdWr, 2'd1, 13'h005, 4'h0, 32'hA0, e);
    wbeat(32'hA1);
    wbeat(32'hA2);
    wbeat(32'hA3);
    idle(2);
    drive(CmdRd, 2'd1, 13'h005, 4'hF, 32'h0, r);
    push(r + 2, 32'hA0); push(r + 3, 32'hA1); push(r + 4, 32'hA2); push(r + 5, 32'hA3);
    idle(8);
    drive(CmdRd, 2'd1, 13'h004, 4'h0, 32'h0, r);
    push(r + 2, 32'hA3); push(r + 3, 32'hA0); push(r + 4, 32'hA1); push(r + 5, 32'hA2);
    idle(8);
    // PRE to a different bank does not cut the burst.
    drive(CmdRd, 2'd1, 13'h005, 4'h0, 32'h0, r);
    drive(CmdPre, 2'd2, 13'h000, 4'h0, 32'h0, e);
    push(r + 2, 32'hA0); push(r + 3, 32'hA1); push(r + 4, 32'hA2); push(r + 5, 32'hA3);
    idle(8);
    // MRS during a burst: in-flight burst keeps BL4/CL2; new mode is CL3 BL1.
    drive(CmdRd, 2'd1, 13'h005, 4'h0, 32'h0, r);
    drive(CmdMrs, 2'd0, 13'h030, 4'h0, 32'h0, e);
    push(r + 2, 32'hA0); push(r + 3, 32'hA1); push(r + 4, 32'hA2); push(r + 5, 32'hA3);
    idle(8);

    // CL3 BL1: byte-masked overwrite, then back-to-back single reads.
    drive(CmdWr, 2'd1, 13'h009, 4'h0, 32'hFFFF_FFFF, e);
    drive(CmdWr, 2'd1, 13'h009, 4'b0101, 32'h1234_5678, e);
    idle(1);
    drive(CmdRd, 2'd1, 13'h009, 4'h0, 32'h0, r);
    push(r + 3, 32'h12FF_56FF);
    idle(6);
    drive(CmdRd, 2'd1, 13'h005, 4'h0, 32'h0, r);
    drive(CmdRd, 2'd1, 13'h004, 4'h0, 32'h0, e);
    push(r + 3, 32'hA0); push(e + 3, 32'hA3);
    idle(6);

    // CL2 BL8: RD interrupted by RD two edges later, gapless.
    drive(CmdMrs, 2'd0, 13'h023, 4'h0, 32'h0, e);
    drive(CmdWr, 2'd1, 13'h010, 4'h0, 32'h100, e);
    for (int k = 1; k < 8; k++) wbeat(32'h100 + 32'(k));
    drive(CmdWr, 2'd1, 13'h018, 4'h0, 32'h200, e);
    for (int k = 1; k < 8; k++) wbeat(32'h200 + 32'(k));
    idle(1);
    drive(CmdRd, 2'd1, 13'h012, 4'h0, 32'h0, r);
    idle(1);
    drive(CmdRd, 2'd1, 13'h01D, 4'h0, 32'h0, e);
    push(r + 2, 32'h102); push(r + 3, 32'h103);
    exp_bl8 = '{32'h205, 32'h206, 32'h207, 32'h200, 32'h201, 32'h202, 32'h203, 32'h204};
    for (int j = 0; j < 8; j++) push(e + 2 + j, exp_bl8[j]);
    idle(12);

    // CL3 BL4: BST after one beat; WR in the CL wait flushes the read.
    drive(CmdMrs, 2'd0, 13'h032, 4'h0, 32'h0, e);
    drive(CmdRd, 2'd1, 13'h005, 4'h0, 32'h0, r);
    drive(CmdBst, 2'd0, 13'h000, 4'h0, 32'h0, e);
    push(r + 3, 32'hA0);
    idle(8);
    drive(CmdRd, 2'd1, 13'h005, 4'h0, 32'h0, r);
    drive(CmdWr, 2'd1, 13'h030, 4'h0, 32'h55, e);
    wbeat(32'h56);
    wbeat(32'h57);
    wbeat(32'h58);
    idle(8);
    drive(CmdRd, 2'd1, 13'h030, 4'h0, 32'h0, r);
    push(r + 3, 32'h55); push(r + 4, 32'h56); push(r + 5, 32'h57); push(r + 6, 32'h58);
    idle(8);
    check("no_proto_err", 32'(proto_err), 32'd0);

    // REF with a bank open, then reset in the middle of a BL8 write.
    drive(CmdMrs, 2'd0, 13'h023, 4'h0, 32'h0, e);
    drive(CmdRef, 2'd0, 13'h000, 4'h0, 32'h0, e);
    idle(1);
    check("ref_cnt_1", 32'(ref_cnt), 32'd1);
    check("err_ref_open", 32'(err_code), ChkEn ? 32'd4 : 32'd0);
    drive(CmdWr, 2'd1, 13'h010, 4'h0, 32'h300, e);
    wbeat(32'h301);
    wbeat(32'h302);
    apply_reset();
    check_reset_state("rst2");
    drive(CmdMrs, 2'd0, 13'h023, 4'h0, 32'h0, e);
    drive(CmdAct, 2'd1, 13'h003, 4'h0, 32'h0, e);
    idle(1);
    drive(CmdRd, 2'd1, 13'h010, 4'h0, 32'h0, r);
    exp_rst = '{32'h300, 32'h301, 32'h302, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
    for (int j = 0; j < 8; j++) push(r + 2 + j, exp_rst[j]);
    idle(12);

    check("expected_beats_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
